// File: rtl/sram_burst_responder.sv
// Word-wide synchronous SRAM responder for the core memory bus. Serves single, INCR and WRAP bursts.
// Latency: accept at edge T, first ACK in cycle T+1+WAIT_STATES, then one beat per cycle with no gaps.
// Backpressure: STALL stays high from the cycle after accept through the last ACK; REQ is sampled only in IDLE.
module sram_burst_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    REQ,
  input  logic [31:0]             ADDR,
  input  logic [1:0]              BURST,
  input  logic                    WRB,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] BSTROBE,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic                    ACK,
  output logic                    STALL
);

  localparam int         LB         = $clog2(BURST_LEN);
  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAST_BURST = 4'(BURST_LEN - 1);
  localparam logic [3:0] WAIT_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BEAT
  } state_t;

  state_t state;
  state_t state_nxt;

  // Transaction context captured at accept; the bus inputs are ignored afterwards.
  logic [ADDR_WIDTH-1:0] base_w;
  logic                  is_wr;
  logic                  is_wrap;
  logic [3:0]            last_idx;
  logic [3:0]            beat_idx;
  logic [3:0]            wait_cnt;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [ADDR_WIDTH-1:0] req_word;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_en;
  logic                  wr_en;
  logic                  last_beat;
  logic                  unused_addr;

  // Word index of beat k: INCR rolls over the array top, WRAP stays inside the aligned block.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] w0,
                                                      input logic [3:0]            k,
                                                      input logic                  wrap);
    logic [ADDR_WIDTH-1:0] lin;
    logic [ADDR_WIDTH-1:0] wrp;
    lin = w0 + ADDR_WIDTH'(k);
    wrp = w0;
    wrp[LB-1:0] = w0[LB-1:0] + k[LB-1:0];
    return wrap ? wrp : lin;
  endfunction

  assign req_word    = ADDR[ADDR_WIDTH+1:2];
  assign unused_addr = ^{ADDR[31:ADDR_WIDTH+2], ADDR[1:0]};
  assign last_beat   = (beat_idx == last_idx);
  assign wr_addr     = beat_addr(base_w, beat_idx, is_wrap);

  // Next state, handshake outputs, and the SRAM read that prefetches the upcoming beat.
  always_comb begin
    state_nxt = state;
    ACK       = 1'b0;
    STALL     = 1'b1;
    rd_en     = 1'b0;
    rd_addr   = '0;
    wr_en     = 1'b0;
    case (state)
      S_IDLE: begin
        STALL = 1'b0;
        if (REQ) begin
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_BEAT;
          // With no wait states the first read data must be fetched on the accept edge.
          if (!WRB && (WAIT_STATES == 0)) begin
            rd_en   = 1'b1;
            rd_addr = req_word;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_BEAT;
          if (!is_wr) begin
            rd_en   = 1'b1;
            rd_addr = base_w;
          end
        end
      end
      S_BEAT: begin
        ACK   = 1'b1;
        wr_en = is_wr;
        if (last_beat) begin
          state_nxt = S_IDLE;
        end else if (!is_wr) begin
          rd_en   = 1'b1;
          rd_addr = beat_addr(base_w, beat_idx + 4'd1, is_wrap);
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus accept-time capture and the wait/beat counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      base_w   <= '0;
      is_wr    <= 1'b0;
      is_wrap  <= 1'b0;
      last_idx <= 4'd0;
      beat_idx <= 4'd0;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (REQ) begin
            base_w   <= req_word;
            is_wr    <= WRB;
            is_wrap  <= (BURST == 2'b10);
            last_idx <= ((BURST == 2'b01) || (BURST == 2'b10)) ? LAST_BURST : 4'd0;
            beat_idx <= 4'd0;
            wait_cnt <= 4'd0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
        end
        S_BEAT: begin
          beat_idx <= last_beat ? 4'd0 : beat_idx + 4'd1;
        end
        default: begin
          beat_idx <= 4'd0;
        end
      endcase
    end
  end

  // Read data register: loaded one edge ahead of each read ACK, holds its value otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RDATA <= '0;
    end else if (rd_en) begin
      RDATA <= mem[rd_addr];
    end
  end

  // Byte-masked SRAM write on the edge that ends each write ACK cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (BSTROBE[i]) begin
          mem[wr_addr][8*i +: 8] <= WDATA[8*i +: 8];
        end
      end
    end
  end

endmodule
